// File: rtl/roi_scan_harness.sv
// Scan harness around a region of interest: serially load a word, apply it, let the ROI
// settle, capture its response and unload it MSB first. Optional macro: ROI_SCAN_PARITY_EN.
module roi_scan_harness #(
   parameter int DIN_N      = 256,
   parameter int DOUT_N     = 256,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              di,
   input  logic              di_valid,
   input  logic              stb,
   output logic [DIN_N-1:0]  roi_din,
   input  logic [DOUT_N-1:0] roi_dout,
   // serial unload data; "do" is a reserved word, hence the suffix
   output logic              do_o,
   output logic              do_valid,
   output logic              busy
);

`ifdef ROI_SCAN_PARITY_EN
   localparam int UNLOAD_N = DOUT_N + 1;
`else
   localparam int UNLOAD_N = DOUT_N;
`endif
   localparam int SCW = $clog2(SETTLE_CYC + 1);
   localparam int BCW = $clog2(UNLOAD_N + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      UNLOAD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DIN_N-1:0]  din_shr_q, din_shr_d;
   logic [DIN_N-1:0]  roi_din_q, roi_din_d;
   logic [DOUT_N-1:0] dout_shr_q, dout_shr_d;
   logic [SCW-1:0]    settle_cnt_q, settle_cnt_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic              do_q, do_d;
   logic              do_valid_q, do_valid_d;
`ifdef ROI_SCAN_PARITY_EN
   logic              par_q, par_d;
`endif

   always_comb begin
      state_d      = state_q;
      din_shr_d    = din_shr_q;
      roi_din_d    = roi_din_q;
      dout_shr_d   = dout_shr_q;
      settle_cnt_d = settle_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      do_d         = 1'b0;
      do_valid_d   = 1'b0;
`ifdef ROI_SCAN_PARITY_EN
      par_d        = par_q;
`endif
      case (state_q)
         IDLE: begin
            // stb takes priority: a coincident di is dropped
            if (stb) begin
               roi_din_d    = din_shr_q;
               settle_cnt_d = '0;
               state_d      = SETTLE;
            end else if (di_valid) begin
               din_shr_d = {din_shr_q[DIN_N-2:0], di};
            end
         end
         SETTLE: begin
            if (settle_cnt_q == SCW'(SETTLE_CYC - 1)) begin
               state_d = CAPTURE;
            end else begin
               settle_cnt_d = settle_cnt_q + SCW'(1);
            end
         end
         CAPTURE: begin
            // the first unload bit is presented at the same edge the word is captured
            dout_shr_d = {roi_dout[DOUT_N-2:0], roi_dout[DOUT_N-1]};
            do_d       = roi_dout[DOUT_N-1];
            do_valid_d = 1'b1;
            bit_cnt_d  = '0;
`ifdef ROI_SCAN_PARITY_EN
            par_d      = ^roi_dout;
`endif
            state_d    = UNLOAD;
         end
         UNLOAD: begin
            if (bit_cnt_q == BCW'(UNLOAD_N - 1)) begin
               state_d = IDLE;
            end else begin
               bit_cnt_d  = bit_cnt_q + BCW'(1);
               dout_shr_d = {dout_shr_q[DOUT_N-2:0], dout_shr_q[DOUT_N-1]};
               do_d       = dout_shr_q[DOUT_N-1];
               do_valid_d = 1'b1;
`ifdef ROI_SCAN_PARITY_EN
               if (bit_cnt_q == BCW'(DOUT_N - 1)) begin
                  do_d = par_q;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         din_shr_q    <= '0;
         roi_din_q    <= '0;
         dout_shr_q   <= '0;
         settle_cnt_q <= '0;
         bit_cnt_q    <= '0;
         do_q         <= 1'b0;
         do_valid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         din_shr_q    <= din_shr_d;
         roi_din_q    <= roi_din_d;
         dout_shr_q   <= dout_shr_d;
         settle_cnt_q <= settle_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         do_q         <= do_d;
         do_valid_q   <= do_valid_d;
      end
   end

`ifdef ROI_SCAN_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end
`endif

   assign roi_din  = roi_din_q;
   assign do_o     = do_q;
   assign do_valid = do_valid_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_roi_scan_harness.sv
// Directed bench for roi_scan_harness at DIN_N=8, DOUT_N=8, SETTLE_CYC=2.
module tb_roi_scan_harness;
   localparam int DIN_N      = 8;
   localparam int DOUT_N     = 8;
   localparam int SETTLE_CYC = 2;

`ifdef ROI_SCAN_PARITY_EN
   localparam int          EXP_VLD  = 9;
   localparam int          EXP_BUSY = 12;
   localparam logic [15:0] EXP_C5   = 16'h018A;
   localparam logic [15:0] EXP_3B   = 16'h0077;
   localparam logic [15:0] EXP_81   = 16'h0102;
`else
   localparam int          EXP_VLD  = 8;
   localparam int          EXP_BUSY = 11;
   localparam logic [15:0] EXP_C5   = 16'h00C5;
   localparam logic [15:0] EXP_3B   = 16'h003B;
   localparam logic [15:0] EXP_81   = 16'h0081;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              di;
   logic              di_valid;
   logic              stb;
   logic [DIN_N-1:0]  roi_din;
   logic [DOUT_N-1:0] roi_dout;
   logic              do_o;
   logic              do_valid;
   logic              busy;

   int n_tests = 0;
   int n_fail  = 0;

   int          busy_cnt, vld_cnt, first_vld, idle_noise, din_changes, stray;
   logic [15:0] word;
   logic [7:0]  din_seen;

   always #5 clk = ~clk;

   roi_scan_harness #(
      .DIN_N     (DIN_N),
      .DOUT_N    (DOUT_N),
      .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .di      (di),
      .di_valid(di_valid),
      .stb     (stb),
      .roi_din (roi_din),
      .roi_dout(roi_dout),
      .do_o    (do_o),
      .do_valid(do_valid),
      .busy    (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic shift_bits(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         di       = bits[i];
         di_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      di_valid = 1'b0;
      di       = 1'b0;
   endtask

   // Pulse stb, then watch 30 cycles; cycle c is sampled on the c-th falling edge after the apply edge.
   task automatic apply_and_watch(input bit inject, input logic [7:0] dout_alt);
      busy_cnt    = 0;
      vld_cnt     = 0;
      first_vld   = 0;
      idle_noise  = 0;
      din_changes = 0;
      word        = '0;
      din_seen    = '0;
      stb = 1'b1;
      @(posedge clk);
      #1;
      stb      = 1'b0;
      di_valid = 1'b0;
      di       = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) din_seen = roi_din;
         else if (roi_din !== din_seen) din_changes++;
         if (busy === 1'b1) busy_cnt++;
         if (do_valid === 1'b1) begin
            if (first_vld == 0) first_vld = c;
            word = {word[14:0], do_o};
            vld_cnt++;
         end else if (do_o !== 1'b0) begin
            idle_noise++;
         end
         if (c == 5) roi_dout = dout_alt;
         if (inject) begin
            if (c == 2 || c == 6) begin
               stb = 1'b1; di_valid = 1'b1; di = 1'b1;
            end else begin
               stb = 1'b0; di_valid = 1'b0; di = 1'b0;
            end
         end
      end
      stb = 1'b0; di_valid = 1'b0; di = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_run(input string tag, input logic [7:0] exp_din, input logic [15:0] exp_word);
      check_eq({tag, "_roi_din"},      32'(din_seen),    32'(exp_din));
      check_eq({tag, "_roi_din_hold"}, din_changes,      0);
      check_eq({tag, "_busy_cycles"},  busy_cnt,         EXP_BUSY);
      check_eq({tag, "_first_valid"},  first_vld,        SETTLE_CYC + 2);
      check_eq({tag, "_valid_count"},  vld_cnt,          EXP_VLD);
      check_eq({tag, "_unload_bits"},  32'(word),        32'(exp_word));
      check_eq({tag, "_do_idle_zero"}, idle_noise,       0);
   endtask

   initial begin
      rst_n    = 1'b0;
      di       = 1'b0;
      di_valid = 1'b0;
      stb      = 1'b0;
      roi_dout = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_roi_din",  32'(roi_din), 0);
      check_eq("rst_do",       32'(do_o),    0);
      check_eq("rst_do_valid", 32'(do_valid), 0);
      check_eq("rst_busy",     32'(busy),    0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // load 1,0,1,1,0,0,1,0 then apply with the ROI returning C5
      shift_bits(8'hB2, 8);
      roi_dout = 8'hC5;
      apply_and_watch(1'b0, 8'hC5);
      check_run("b2_c5", 8'hB2, EXP_C5);

      // requests during busy must be ignored; ROI input changes after capture must not leak
      roi_dout = 8'h3B;
      apply_and_watch(1'b1, 8'hFF);
      check_run("busy_ignore", 8'hB2, EXP_3B);

      // din_shr held through the ignored di_valid pulses
      roi_dout = 8'h81;
      apply_and_watch(1'b0, 8'h00);
      check_run("din_hold", 8'hB2, EXP_81);

      // stb and di_valid together after three shifted ones
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      shift_bits(8'h07, 3);
      roi_dout = 8'hC5;
      di_valid = 1'b1;
      di       = 1'b1;
      apply_and_watch(1'b0, 8'hC5);
      check_eq("stb_wins_roi_din", 32'(din_seen), 32'h07);
      apply_and_watch(1'b0, 8'hC5);
      check_eq("di_dropped", 32'(din_seen), 32'h07);

      // partial load keeps the unshifted history
      shift_bits(8'h02, 2);
      apply_and_watch(1'b0, 8'hC5);
      check_eq("partial_load", 32'(din_seen), 32'h1E);

      // reset in the third unload cycle
      roi_dout = 8'hFF;
      stb = 1'b1;
      @(posedge clk);
      #1;
      stb = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("pre_rst_do_valid", 32'(do_valid), 1);
      check_eq("pre_rst_do",       32'(do_o),     1);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_do",       32'(do_o),     0);
      check_eq("mid_rst_do_valid", 32'(do_valid), 0);
      check_eq("mid_rst_busy",     32'(busy),     0);
      check_eq("mid_rst_roi_din",  32'(roi_din),  0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stray = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (do_valid !== 1'b0 || busy !== 1'b0) stray++;
      end
      check_eq("post_rst_quiet", stray, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
